acc_drain_serializer: RTL and testbench
=======================================

Name: acc_drain_serializer

Overview:
Downstream stage of the T×T PE mesh. Watches the mesh's accumulator snapshot grid and its per-PE valid grid. Once every PE has latched its result, it copies the whole grid into a local snapshot, freeing the mesh for the next block's clear and compute. It then streams the T*T results row-major over a valid/ready interface to the writeback/output buffer.

Parameters:
- T, mm_pkg::T, mesh dimension (results per block = T*T).
- ACCW, mm_pkg::ACCW, accumulator width per PE.
- OW, mm_pkg::OW, output element width; OW <= ACCW.
- SIGNED_M, mm_pkg::SIGNED_M, accumulators are two's-complement when 1; used by narrowing.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; a block's drain has been injected, collect its results.
- acc_mat  in  [T-1:0][T-1:0][ACCW-1:0]  mesh accumulator snapshot grid.
- acc_v_mat  in  [T-1:0][T-1:0]  per-PE snapshot valid.
- out_data  out  OW  result element.
- out_valid  out  1  element valid.
- out_ready  in  1  downstream accept.
- out_row  out  $clog2(T) (min 1)  row index of out_data.
- out_col  out  $clog2(T) (min 1)  column index of out_data.
- out_last  out  1  high with element (T-1,T-1).
- out_sat  out  1  element was saturated; only driven with the optional feature.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last handshake.
- arm_err  out  1  sticky; arm seen while busy; cleared only by reset.

Behaviour:
- Reset (async, any state): state = IDLE. All of the following go to 0: out_data, out_valid, out_row, out_col, out_last, out_sat, busy, done, arm_err, snapshot regs, indices.
- FSM states: IDLE, WAIT_ALL, STREAM (mm_pkg::drain_state_e).
- IDLE:
  - arm = 1 -> WAIT_ALL next edge.
  - out_valid = 0.
- WAIT_ALL:
  - If &acc_v_mat is sampled 1 at edge N: all T*T acc_mat entries are copied into the snapshot, row/col = 0, state = STREAM.
  - out_valid = 1 from edge N (first element visible in the cycle after all-valid is seen).
  - No timeout; waits indefinitely.
- STREAM:
  - out_data = narrow(snapshot[row][col]); out_row/out_col = row/col; out_last = (row==T-1 && col==T-1).
  - Handshake when out_valid & out_ready at an edge: col increments; at col==T-1, col wraps to 0 and row increments.
  - While out_valid & !out_ready, out_data/row/col/last/sat hold stable; out_valid never drops without a handshake.
  - Handshake with out_last = 1 -> IDLE, out_valid = 0, done = 1 for exactly one cycle.
- Throughput: one element per cycle with out_ready held high. Block latency = T*T cycles from first valid to done.
- Snapshot isolation: acc_mat/acc_v_mat changes during STREAM (mesh clearing, next block) do not affect output.
- arm while busy: ignored, arm_err <= 1.
- arm in the same cycle as the final handshake: the FSM is still STREAM, so it is an error; it is not queued.
- Narrowing, OW < ACCW, default build: truncate to the low OW bits; out_sat = 0.
- Narrowing, OW == ACCW: pass-through; out_sat = 0.
- acc_v_mat partially set: remain in WAIT_ALL; all T*T bits are required.

Optional Feature:
- Macro MM_DRAIN_SAT_EN.
- Defined:
  - narrow() saturates to the OW range (signed range when SIGNED_M, else 0..2^OW-1).
  - out_sat = 1 when clamping occurred, registered alongside out_data.
- Undefined: plain truncation; out_sat tied 0.

Decomposition:
- mm_pkg adds:
  - OW constant.
  - drain_state_e enum {IDLE, WAIT_ALL, STREAM}.
  - IDXW = (T>1 ? $clog2(T) : 1) localparam.
- Sub-module acc_narrow: combinational ACCW->OW truncate/saturate.
  - Parameters ACCW, OW, SIGNED_M.
  - Outputs value and sat flag.
  - Contains the MM_DRAIN_SAT_EN conditional.

Test Plan (T=4, ACCW=32, OW=16, SIGNED_M=1):
1. arm; all acc_v_mat set with acc_mat[i][j]=i*4+j; out_ready=1 -> 16 consecutive beats 0..15, row/col match, out_last only on beat 15, done pulse one cycle after, busy low after.
2. Same as 1, but out_ready toggled 1,0,0,1 pattern -> data/row/col held stable during stalls, no drops/duplicates, order 0..15.
3. acc_v_mat set one PE per cycle in serpentine order -> out_valid stays 0 until the 16th bit is set, then first beat appears the next cycle.
4. After capture, drive acc_mat to 0xDEAD and acc_v_mat to 0 mid-stream -> remaining beats still carry the original snapshot values.
5. arm pulsed during STREAM -> arm_err=1 and sticky, stream unaffected; async reset mid-stream -> all outputs 0 immediately, arm_err cleared, next arm works.
6. acc_mat[0][0]=70000, acc_mat[0][1]=-70000 -> with MM_DRAIN_SAT_EN: 32767/-32768, out_sat=1; without: 0x1170/0xEE90, out_sat=0.

Source files
------------

// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared constants and types for the matrix-multiply mesh slice.
//   T        : mesh dimension (T x T processing elements)
//   ACCW     : accumulator width per PE
//   OW       : width of an element leaving the drain serializer (OW <= ACCW)
//   SIGNED_M : accumulators are two's complement when 1
//   IDXW     : width of a row/column index (at least 1 bit)
//   drain_state_e : drain serializer FSM states
// ---------------------------------------------------------------------------
package mm_pkg;

    localparam int T        = 4;
    localparam int ACCW     = 32;
    localparam int OW       = 16;
    localparam int SIGNED_M = 1;
    localparam int IDXW     = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ALL = 2'd1,
        STREAM   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/acc_drain_serializer_if.sv
// ---------------------------------------------------------------------------
// acc_drain_serializer_if
// Valid/ready output stream from the drain serializer to the writeback
// buffer. One element per handshake, tagged with its mesh coordinates.
//   out_data  : narrowed result element (OW bits)
//   out_valid : element valid
//   out_ready : downstream accepts the element
//   out_row   : row index of out_data
//   out_col   : column index of out_data
//   out_last  : element (T-1,T-1) of the block
//   out_sat   : element was clamped while narrowing
// Modports: master = serializer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface acc_drain_serializer_if;

    logic [mm_pkg::OW-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [mm_pkg::IDXW-1:0] out_row;
    logic [mm_pkg::IDXW-1:0] out_col;
    logic                    out_last;
    logic                    out_sat;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready,
        output out_row,
        output out_col,
        output out_last,
        output out_sat
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_row,
        input  out_col,
        input  out_last,
        input  out_sat
    );

endinterface

// File: rtl/acc_drain_serializer_acc_narrow.sv
// ---------------------------------------------------------------------------
// acc_narrow
// Combinational ACCW -> OW narrowing of one accumulator value.
//   acc_in  : accumulator value (ACCW bits)
//   val_out : narrowed value (OW bits)
//   sat_out : 1 when the value had to be clamped
// Build option: MM_DRAIN_SAT_EN
//   defined   -> saturate to the OW range (signed when SIGNED_M != 0,
//                otherwise 0 .. 2^OW-1) and flag clamping on sat_out
//   undefined -> keep the low OW bits; sat_out is always 0
// When OW == ACCW the value passes through untouched.
// ---------------------------------------------------------------------------
module acc_narrow #(
    parameter int ACCW     = 32,
    parameter int OW       = 16,
    parameter int SIGNED_M = 1
) (
    input  logic [ACCW-1:0] acc_in,
    output logic [OW-1:0]   val_out,
    output logic            sat_out
);

    generate
        if (OW == ACCW) begin : g_pass
            assign val_out = acc_in;
            assign sat_out = 1'b0;
        end else begin : g_narrow
`ifdef MM_DRAIN_SAT_EN
            if (SIGNED_M != 0) begin : g_signed
                // Representable in OW signed bits iff every bit from the OW
                // sign position upward is a copy of the sign.
                logic [ACCW-OW:0] hi_bits;
                logic             in_range;
                assign hi_bits  = acc_in[ACCW-1:OW-1];
                assign in_range = (&hi_bits) | (~|hi_bits);
                always_comb begin
                    val_out = acc_in[OW-1:0];
                    sat_out = 1'b0;
                    if (!in_range) begin
                        sat_out = 1'b1;
                        val_out = acc_in[ACCW-1] ? {1'b1, {(OW-1){1'b0}}}
                                                 : {1'b0, {(OW-1){1'b1}}};
                    end
                end
            end else begin : g_unsigned
                logic [ACCW-OW-1:0] hi_bits;
                assign hi_bits = acc_in[ACCW-1:OW];
                always_comb begin
                    val_out = acc_in[OW-1:0];
                    sat_out = 1'b0;
                    if (|hi_bits) begin
                        sat_out = 1'b1;
                        val_out = {OW{1'b1}};
                    end
                end
            end
`else
            // Plain truncation; the discarded upper bits are intentionally dropped.
            logic [ACCW-OW-1:0] unused_hi;
            assign unused_hi = acc_in[ACCW-1:OW];
            assign val_out   = acc_in[OW-1:0];
            assign sat_out   = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: rtl/acc_drain_serializer.sv
// ---------------------------------------------------------------------------
// acc_drain_serializer
// Collects a finished block from the T x T PE mesh and streams it out.
// After an arm pulse it waits until every PE reports a valid result, copies
// the whole accumulator grid into a local snapshot (so the mesh can start
// clearing for the next block straight away) and then emits the T*T
// results row-major over a valid/ready stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   arm        : one-cycle pulse, collect the block now draining
//   acc_mat    : mesh accumulator grid
//   acc_v_mat  : per-PE result-valid grid
//   out_if     : output stream (data, valid, ready, row, col, last, sat)
//   busy       : FSM is not idle
//   done       : one-cycle pulse after the final handshake of a block
//   arm_err    : sticky, arm arrived while busy (cleared only by reset)
// Build option: MM_DRAIN_SAT_EN selects saturating narrowing (see acc_narrow).
// ---------------------------------------------------------------------------
module acc_drain_serializer
    import mm_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           arm,
    input  logic [T-1:0][T-1:0][ACCW-1:0]  acc_mat,
    input  logic [T-1:0][T-1:0]            acc_v_mat,
    acc_drain_serializer_if.master         out_if,
    output logic                           busy,
    output logic                           done,
    output logic                           arm_err
);

    drain_state_e                  state_q, state_d;
    logic [T-1:0][T-1:0][ACCW-1:0] snap_q;
    logic                          capture;
    logic [IDXW-1:0]               row_q, row_d, col_q, col_d;
    logic [IDXW-1:0]               row_nx, col_nx;
    logic [OW-1:0]                 data_q, data_d;
    logic                          sat_q, sat_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          done_q, done_d;
    logic                          arm_err_q, arm_err_d;

    logic [ACCW-1:0]               narrow_in;
    logic [OW-1:0]                 narrow_val;
    logic                          narrow_sat;

    // Output element is registered: the narrower sees the element that will
    // be presented after the coming edge, not the one currently on the bus.
    acc_narrow #(
        .ACCW     (ACCW),
        .OW       (OW),
        .SIGNED_M (SIGNED_M)
    ) u_narrow (
        .acc_in  (narrow_in),
        .val_out (narrow_val),
        .sat_out (narrow_sat)
    );

    // Row-major successor of the current coordinate.
    always_comb begin
        row_nx = row_q;
        col_nx = col_q + 1'b1;
        if (col_q == IDXW'(T-1)) begin
            col_nx = '0;
            row_nx = row_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        data_d    = data_q;
        sat_d     = sat_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        capture   = 1'b0;
        narrow_in = snap_q[row_nx][col_nx];
        // Any arm outside IDLE is dropped, including one coinciding with
        // the final handshake: blocks are never queued.
        arm_err_d = arm_err_q | (arm & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (arm) begin
                    state_d = WAIT_ALL;
                end
            end
            WAIT_ALL: begin
                if (&acc_v_mat) begin
                    capture   = 1'b1;
                    narrow_in = acc_mat[0][0];
                    state_d   = STREAM;
                    row_d     = '0;
                    col_d     = '0;
                    data_d    = narrow_val;
                    sat_d     = narrow_sat;
                    valid_d   = 1'b1;
                    last_d    = (T == 1);
                end
            end
            STREAM: begin
                if (valid_q && out_if.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        sat_d   = 1'b0;
                        row_d   = '0;
                        col_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d  = row_nx;
                        col_d  = col_nx;
                        data_d = narrow_val;
                        sat_d  = narrow_sat;
                        last_d = (row_nx == IDXW'(T-1)) && (col_nx == IDXW'(T-1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            arm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            data_q    <= data_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            arm_err_q <= arm_err_d;
        end
    end

    // Snapshot: loaded in one shot when the whole grid is valid, then held
    // for the rest of the stream regardless of what the mesh does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (capture) begin
            snap_q <= acc_mat;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_col   = col_q;
    assign out_if.out_last  = last_q;
    assign out_if.out_sat   = sat_q;
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign arm_err          = arm_err_q;

endmodule

// File: tb/tb_acc_drain_serializer.sv
// ---------------------------------------------------------------------------
// tb_acc_drain_serializer
// Self-checking bench for acc_drain_serializer. Expected beats come from a
// row-major walk of the grid the bench drove, narrowed with plain integer
// arithmetic. Honours MM_DRAIN_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_acc_drain_serializer;
    import mm_pkg::*;

    localparam int NB = T * T;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          arm;
    logic [T-1:0][T-1:0][ACCW-1:0] acc_mat;
    logic [T-1:0][T-1:0]           acc_v_mat;
    logic                          busy;
    logic                          done;
    logic                          arm_err;

    acc_drain_serializer_if ifc ();

    acc_drain_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .acc_mat   (acc_mat),
        .acc_v_mat (acc_v_mat),
        .out_if    (ifc),
        .busy      (busy),
        .done      (done),
        .arm_err   (arm_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int            grid [T][T];
    logic [OW-1:0] got_data [NB];
    int            got_row  [NB];
    int            got_col  [NB];
    logic          got_last [NB];
    logic          got_sat  [NB];
    int            got_cyc  [NB];
    int            n_got, stall_viol, done_len, done_cyc;
    bit            timed_out;

    // Reference narrowing: signed accumulators, clamp or wrap to OW bits.
    function automatic logic [OW-1:0] model_val(input int v);
        longint lv;
        longint hi;
        longint lo;
        lv = v;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
`ifdef MM_DRAIN_SAT_EN
        if (lv > hi) lv = hi;
        if (lv < lo) lv = lo;
`endif
        return lv[OW-1:0];
    endfunction

    function automatic logic model_sat(input int v);
        longint lv;
        lv = v;
`ifdef MM_DRAIN_SAT_EN
        return (lv > ((longint'(1) <<< (OW - 1)) - 1)) || (lv < -(longint'(1) <<< (OW - 1)));
`else
        return (lv != lv);
`endif
    endfunction

    task automatic drive_grid();
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                acc_mat[i][j] = ACCW'(grid[i][j]);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    // Consumer: drives out_ready per mode (0 always, 1 = 1,0,0,1 pattern,
    // 2 random), records accepted beats, counts stall instabilities, and can
    // corrupt the mesh inputs or pulse arm when a given beat is accepted.
    task automatic collect(input int mode, input int max_beats,
                           input int corrupt_at, input int arm_at);
        logic          stalled;
        logic          rdy;
        logic [OW-1:0] sd;
        logic [IDXW-1:0] sr, sc;
        logic          sl, ss;
        bit            finished;
        stalled = 1'b0; finished = 1'b0;
        n_got = 0; stall_viol = 0; done_len = 0; done_cyc = -1; timed_out = 1'b0;
        sd = '0; sr = '0; sc = '0; sl = 1'b0; ss = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (stalled && (ifc.out_valid !== 1'b1 || ifc.out_data !== sd ||
                            ifc.out_row !== sr || ifc.out_col !== sc ||
                            ifc.out_last !== sl || ifc.out_sat !== ss))
                stall_viol++;
            if (done === 1'b1) begin
                if (done_len == 0) done_cyc = cyc;
                done_len++;
            end
            if (done_len > 0 && done !== 1'b1) begin
                finished = 1'b1;
            end else if (n_got >= max_beats) begin
                finished = 1'b1;
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: rdy = 1'(($urandom_range(0, 1)));
                endcase
                ifc.out_ready = rdy;
                if (n_got == corrupt_at) begin
                    for (int i = 0; i < T; i++)
                        for (int j = 0; j < T; j++)
                            acc_mat[i][j] = ACCW'(32'hDEAD);
                    acc_v_mat = '0;
                end
                arm = (ifc.out_valid === 1'b1) && rdy && (n_got == arm_at);
                if (ifc.out_valid === 1'b1 && rdy) begin
                    if (n_got < NB) begin
                        got_data[n_got] = ifc.out_data;
                        got_row[n_got]  = int'(ifc.out_row);
                        got_col[n_got]  = int'(ifc.out_col);
                        got_last[n_got] = ifc.out_last;
                        got_sat[n_got]  = ifc.out_sat;
                        got_cyc[n_got]  = cyc;
                    end
                    n_got++;
                    stalled = 1'b0;
                end else if (ifc.out_valid === 1'b1) begin
                    stalled = 1'b1;
                    sd = ifc.out_data; sr = ifc.out_row; sc = ifc.out_col;
                    sl = ifc.out_last; ss = ifc.out_sat;
                end else begin
                    stalled = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        arm = 1'b0;
        ifc.out_ready = 1'b0;
        if (!finished) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; acc_mat = '0; acc_v_mat = '0; ifc.out_ready = 1'b0;
        #3;
        n_checks++;
        if ({ifc.out_data, ifc.out_valid, ifc.out_row, ifc.out_col, ifc.out_last,
             ifc.out_sat, busy, done, arm_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%0h valid=%0b busy=%0b done=%0b err=%0b required all zero",
                     ifc.out_data, ifc.out_valid, busy, done, arm_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%0b valid=%0b required 0 0", busy, ifc.out_valid);
        end
        $display("reset: released");
    endtask

    task automatic test_full_rate();
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                grid[i][j] = i * T + j;
        drive_grid();
        acc_v_mat = '1;
        pulse_arm();
        collect(0, NB, -1, -1);
        n_checks++;
        if (timed_out || n_got != NB) begin
            n_fail++;
            $display("FAIL full_count: got %0d beats timeout=%0b required %0d", n_got, timed_out, NB);
        end
        for (int k = 0; k < NB && k < n_got; k++) begin
            n_checks++;
            if (got_data[k] !== model_val(grid[k / T][k % T]) || got_row[k] != k / T ||
                got_col[k] != k % T || got_last[k] !== (k == NB - 1)) begin
                n_fail++;
                $display("FAIL full_beat%0d: got data=%0h r=%0d c=%0d last=%0b required data=%0h r=%0d c=%0d last=%0b",
                         k, got_data[k], got_row[k], got_col[k], got_last[k],
                         model_val(grid[k / T][k % T]), k / T, k % T, (k == NB - 1));
            end
        end
        n_checks++;
        if (n_got == NB && got_cyc[NB-1] - got_cyc[0] != NB - 1) begin
            n_fail++;
            $display("FAIL full_throughput: got span %0d required %0d", got_cyc[NB-1] - got_cyc[0], NB - 1);
        end
        n_checks++;
        if (done_len != 1 || (n_got > 0 && done_cyc - got_cyc[0] != NB)) begin
            n_fail++;
            $display("FAIL full_done: got len=%0d latency=%0d required len=1 latency=%0d",
                     done_len, done_cyc - got_cyc[0], NB);
        end
        n_checks++;
        if (busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_idle_after: got busy=%0b valid=%0b required 0 0", busy, ifc.out_valid);
        end
        $display("full_rate: %0d beats, done after %0d cycles", n_got, done_cyc);
    endtask

    task automatic test_stall();
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                grid[i][j] = i * T + j;
        drive_grid();
        acc_v_mat = '1;
        pulse_arm();
        collect(1, NB, -1, -1);
        n_checks++;
        if (timed_out || n_got != NB || stall_viol != 0 || done_len != 1) begin
            n_fail++;
            $display("FAIL stall_stream: got beats=%0d stall_viol=%0d done_len=%0d timeout=%0b required %0d 0 1 0",
                     n_got, stall_viol, done_len, timed_out, NB);
        end
        for (int k = 0; k < NB && k < n_got; k++) begin
            n_checks++;
            if (got_data[k] !== model_val(grid[k / T][k % T]) || got_row[k] != k / T || got_col[k] != k % T) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got data=%0h r=%0d c=%0d required data=%0h r=%0d c=%0d",
                         k, got_data[k], got_row[k], got_col[k], model_val(grid[k / T][k % T]), k / T, k % T);
            end
        end
        $display("stall: %0d beats, %0d stall violations", n_got, stall_viol);
    endtask

    task automatic test_serpentine();
        int r, c;
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                grid[i][j] = 100 + i * 7 - j * 3;
        drive_grid();
        acc_v_mat = '0;
        pulse_arm();
        for (int k = 0; k < NB; k++) begin
            r = k / T;
            c = (r % 2 == 0) ? (k % T) : (T - 1 - k % T);
            acc_v_mat[r][c] = 1'b1;
            n_checks++;
            if (ifc.out_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL serp_wait%0d: got valid=%0b busy=%0b required 0 1", k, ifc.out_valid, busy);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== model_val(grid[0][0])) begin
            n_fail++;
            $display("FAIL serp_first: got valid=%0b data=%0h required 1 %0h",
                     ifc.out_valid, ifc.out_data, model_val(grid[0][0]));
        end
        collect(0, NB, -1, -1);
        n_checks++;
        if (timed_out || n_got != NB || done_len != 1) begin
            n_fail++;
            $display("FAIL serp_stream: got beats=%0d done_len=%0d required %0d 1", n_got, done_len, NB);
        end
        $display("serpentine: %0d beats", n_got);
    endtask

    task automatic test_snapshot_isolation();
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                grid[i][j] = 1000 + i * T + j;
        drive_grid();
        acc_v_mat = '1;
        pulse_arm();
        collect(0, NB, 5, -1);
        n_checks++;
        if (timed_out || n_got != NB) begin
            n_fail++;
            $display("FAIL iso_count: got %0d required %0d", n_got, NB);
        end
        for (int k = 0; k < NB && k < n_got; k++) begin
            n_checks++;
            if (got_data[k] !== model_val(grid[k / T][k % T])) begin
                n_fail++;
                $display("FAIL iso_beat%0d: got %0h required %0h", k, got_data[k], model_val(grid[k / T][k % T]));
            end
        end
        $display("snapshot_isolation: %0d beats", n_got);
    endtask

    task automatic test_arm_err_and_reset();
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                grid[i][j] = 50 * i + j;
        drive_grid();
        acc_v_mat = '1;
        n_checks++;
        if (arm_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear_before: got %0b required 0", arm_err);
        end
        pulse_arm();
        collect(0, NB, -1, 5);
        n_checks++;
        if (arm_err !== 1'b1 || n_got != NB || done_len != 1) begin
            n_fail++;
            $display("FAIL err_mid_stream: got err=%0b beats=%0d done_len=%0d required 1 %0d 1",
                     arm_err, n_got, done_len, NB);
        end
        for (int k = 0; k < NB && k < n_got; k++) begin
            n_checks++;
            if (got_data[k] !== model_val(grid[k / T][k % T])) begin
                n_fail++;
                $display("FAIL err_beat%0d: got %0h required %0h", k, got_data[k], model_val(grid[k / T][k % T]));
            end
        end
        // arm coinciding with the final handshake must not start a new block.
        pulse_arm();
        collect(0, NB, -1, NB - 1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (busy !== 1'b0 || ifc.out_valid !== 1'b0 || arm_err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_not_queued%0d: got busy=%0b valid=%0b err=%0b required 0 0 1",
                         k, busy, ifc.out_valid, arm_err);
            end
            @(posedge clk); #1;
        end
        // Asynchronous reset in the middle of a stream.
        pulse_arm();
        collect(0, 6, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc.out_data, ifc.out_valid, ifc.out_row, ifc.out_col, ifc.out_last,
             ifc.out_sat, busy, done, arm_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got data=%0h valid=%0b busy=%0b err=%0b required all zero",
                     ifc.out_data, ifc.out_valid, busy, arm_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_arm();
        collect(0, NB, -1, -1);
        n_checks++;
        if (timed_out || n_got != NB || done_len != 1 || arm_err !== 1'b0 ||
            got_data[0] !== model_val(grid[0][0]) || got_data[NB-1] !== model_val(grid[T-1][T-1])) begin
            n_fail++;
            $display("FAIL rearm_after_reset: got beats=%0d done_len=%0d err=%0b first=%0h required %0d 1 0 %0h",
                     n_got, done_len, arm_err, got_data[0], NB, model_val(grid[0][0]));
        end
        $display("arm_err_and_reset: final stream %0d beats", n_got);
    endtask

    task automatic test_narrowing();
        logic [OW-1:0] exp0, exp1;
        logic          esat;
`ifdef MM_DRAIN_SAT_EN
        exp0 = 16'h7FFF; exp1 = 16'h8000; esat = 1'b1;
`else
        exp0 = 16'h1170; exp1 = 16'hEE90; esat = 1'b0;
`endif
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++)
                grid[i][j] = -8 + i * T + j;
        grid[0][0] = 70000;
        grid[0][1] = -70000;
        drive_grid();
        acc_v_mat = '1;
        pulse_arm();
        collect(0, NB, -1, -1);
        n_checks++;
        if (got_data[0] !== exp0 || got_sat[0] !== esat || got_data[1] !== exp1 || got_sat[1] !== esat) begin
            n_fail++;
            $display("FAIL narrow_edge: got %0h/%0b %0h/%0b required %0h/%0b %0h/%0b",
                     got_data[0], got_sat[0], got_data[1], got_sat[1], exp0, esat, exp1, esat);
        end
        for (int k = 0; k < NB && k < n_got; k++) begin
            n_checks++;
            if (got_data[k] !== model_val(grid[k / T][k % T]) || got_sat[k] !== model_sat(grid[k / T][k % T])) begin
                n_fail++;
                $display("FAIL narrow_beat%0d: got %0h sat=%0b required %0h sat=%0b", k, got_data[k],
                         got_sat[k], model_val(grid[k / T][k % T]), model_sat(grid[k / T][k % T]));
            end
        end
        $display("narrowing: first=%0h second=%0h", got_data[0], got_data[1]);
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < T; i++)
                for (int j = 0; j < T; j++)
                    grid[i][j] = (blk == 0) ? int'($urandom_range(0, 60000)) - 30000 : int'($urandom);
            drive_grid();
            acc_v_mat = '1;
            pulse_arm();
            collect(2, NB, -1, -1);
            n_checks++;
            if (timed_out || n_got != NB || stall_viol != 0 || done_len != 1) begin
                n_fail++;
                $display("FAIL rand%0d_stream: got beats=%0d stall_viol=%0d done_len=%0d required %0d 0 1",
                         blk, n_got, stall_viol, done_len, NB);
            end
            for (int k = 0; k < NB && k < n_got; k++) begin
                n_checks++;
                if (got_data[k] !== model_val(grid[k / T][k % T]) || got_sat[k] !== model_sat(grid[k / T][k % T]) ||
                    got_row[k] != k / T || got_col[k] != k % T) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %0h sat=%0b r=%0d c=%0d required %0h sat=%0b r=%0d c=%0d",
                             blk, k, got_data[k], got_sat[k], got_row[k], got_col[k],
                             model_val(grid[k / T][k % T]), model_sat(grid[k / T][k % T]), k / T, k % T);
                end
            end
            $display("random block %0d: %0d beats", blk, n_got);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_serpentine();
        test_snapshot_isolation();
        test_arm_err_and_reset();
        test_narrowing();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
